regfile_syscall_unit: RTL and testbench
=======================================

Name: regfile_syscall_unit

Overview:
- Decode-stage register file. It directly consumes the operand-select stage's outputs: R1Adr, R2Adr, WAdr and RDin.
- Holds 32 x 32-bit MIPS GPRs: two combinational read ports, one synchronous write port, write-through bypass.
- Also evaluates SYSCALL: it latches the display value ($a0) or raises a sticky Halt ($v0 == HALT_CODE). The operand-select stage forces R1Adr=2 and R2Adr=4 during SYSCALL.

Parameters:
- HALT_CODE, 10, $v0 value that halts the CPU on SYSCALL
- SP_INIT, 32'h0000_0000, reset value of register 29 ($sp)
- DATA_W, 32, register width (only 32 supported)

Ports:
- CLK  input  1  system clock, rising edge active
- RST_N  input  1  reset, synchronous, active-low (one clock; reset is synchronous and active-low)
- WE  input  1  register write enable from WB stage
- WAdr  input  5  write register number
- RDin  input  32  write data
- R1Adr  input  5  read port 1 register number
- R2Adr  input  5  read port 2 register number
- Syscall  input  1  SYSCALL instruction present in decode
- DbgAdr  input  5  debug read register number
- R1  output  32  read port 1 data
- R2  output  32  read port 2 data
- DbgData  output  32  debug read data (no bypass)
- LedData  output  32  last displayed syscall value
- LedStrobe  output  1  one-cycle pulse when LedData updates
- Halt  output  1  sticky halt request to PC/pipeline control

Behaviour:
- Reset: sampled at rising CLK edge with RST_N=0.
  - All GPRs go to 0, except reg 29, which goes to SP_INIT.
  - LedData=0, LedStrobe=0, Halt=0.
  - Reset overrides a simultaneous write or syscall.
  - Reset while Halt=1 clears Halt.
- Write:
  - At a rising edge with RST_N=1, WE=1 and WAdr!=0: reg[WAdr] <= RDin.
  - WAdr=0 writes are discarded; reg 0 always reads 0.
  - Writes continue while Halt=1 so the pipeline can drain.
- Read (combinational, zero latency):
  - Rx = 0 if RxAdr==0.
  - Otherwise Rx = RDin if WE=1 and WAdr==RxAdr (write-through bypass).
  - Otherwise Rx = reg[RxAdr].
  - R1 and R2 may address the same register; both get identical data.
  - DbgData = reg[DbgAdr] with no bypass: it shows the written value one cycle after the edge.
- Syscall evaluation:
  - Evaluated on a rising edge with RST_N=1, Syscall=1 and Halt=0.
  - Uses the bypassed R1/R2 values of that cycle.
  - R1 == HALT_CODE: Halt <= 1. LedData is unchanged and LedStrobe stays 0.
  - R1 != HALT_CODE: LedData <= R2 and LedStrobe <= 1 for exactly one cycle.
  - LedStrobe <= 0 on every other edge.
  - Back-to-back Syscall cycles each update LedData and keep LedStrobe high for consecutive cycles.
  - Syscall while Halt=1 is ignored; Halt stays 1 until reset.
- Latency:
  - A write is visible on R1/R2 in the same cycle (bypass) and on DbgData next cycle.
  - Halt and LedData appear one cycle after the Syscall edge.
- All arithmetic is comparison only; no width extension is performed.
- Undriven/X inputs while RST_N=0 must not corrupt the reset values.

Test Plan:
- Reset with SP_INIT=32'h0000_3FFC, hold RST_N=0 two cycles -> R1Adr=29 gives 32'h0000_3FFC; R1Adr=5 gives 0; Halt=0, LedData=0, LedStrobe=0.
- Write/bypass: WE=1, WAdr=8, RDin=32'hDEAD_BEEF, R1Adr=8 in the same cycle -> R1=32'hDEAD_BEEF before the edge; DbgAdr=8 gives DbgData=0 before the edge and 32'hDEAD_BEEF after it.
- Zero register: WE=1, WAdr=0, RDin=32'hFFFF_FFFF -> R1Adr=R2Adr=0 read 0 before and after the edge; DbgAdr=0 reads 0.
- Display: reg2=34, reg4=32'h1234_5678, Syscall=1 one cycle -> next cycle LedData=32'h1234_5678, LedStrobe=1 for one cycle, Halt=0.
- Halt with bypass: WE=1, WAdr=2, RDin=10 in the same cycle as Syscall=1 with R1Adr=2 -> Halt=1 next cycle and LedData unchanged; later Syscall with reg2=1, reg4=7 -> LedData unchanged, LedStrobe=0, Halt stays 1.
- Reset mid-halt: Halt=1, then RST_N=0 for one edge -> Halt=0 and all GPRs except 29 read 0; a write issued in the reset cycle is not stored.

Source files
------------

// File: rtl/regfile_syscall_unit_if.sv
// -----------------------------------------------------------------------------
// regfile_syscall_unit_if
//   Bundles the decode-stage register file signals between the pipeline
//   (master) and the register file / syscall unit (slave).
//
//   Signal summary (direction as seen by the slave):
//     WE        in   write enable from WB stage
//     WAdr      in   write register number
//     RDin      in   write data
//     R1Adr     in   read port 1 register number
//     R2Adr     in   read port 2 register number
//     Syscall   in   SYSCALL instruction present in decode
//     DbgAdr    in   debug read register number
//     R1        out  read port 1 data (bypassed)
//     R2        out  read port 2 data (bypassed)
//     DbgData   out  debug read data (no bypass)
//     LedData   out  last displayed syscall value
//     LedStrobe out  one-cycle pulse when LedData updates
//     Halt      out  sticky halt request
// -----------------------------------------------------------------------------
interface regfile_syscall_unit_if #(
    parameter int DATA_W = 32
);
    logic              WE;
    logic [4:0]        WAdr;
    logic [DATA_W-1:0] RDin;
    logic [4:0]        R1Adr;
    logic [4:0]        R2Adr;
    logic              Syscall;
    logic [4:0]        DbgAdr;
    logic [DATA_W-1:0] R1;
    logic [DATA_W-1:0] R2;
    logic [DATA_W-1:0] DbgData;
    logic [DATA_W-1:0] LedData;
    logic              LedStrobe;
    logic              Halt;

    modport master (
        output WE, WAdr, RDin, R1Adr, R2Adr, Syscall, DbgAdr,
        input  R1, R2, DbgData, LedData, LedStrobe, Halt
    );

    modport slave (
        input  WE, WAdr, RDin, R1Adr, R2Adr, Syscall, DbgAdr,
        output R1, R2, DbgData, LedData, LedStrobe, Halt
    );
endinterface

// File: rtl/regfile_syscall_unit.sv
// -----------------------------------------------------------------------------
// regfile_syscall_unit
//   Decode-stage MIPS register file (32 x 32-bit) with two combinational
//   read ports, one synchronous write port and write-through bypass, plus
//   SYSCALL evaluation: either latch $a0 into the display register or raise
//   a sticky halt when $v0 equals HALT_CODE.
//
//   Ports:
//     CLK    in   system clock, rising edge active
//     RST_N  in   synchronous active-low reset
//     bus    slave modport of regfile_syscall_unit_if (see interface header)
// -----------------------------------------------------------------------------
module regfile_syscall_unit #(
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] HALT_CODE = 10,
    parameter logic [DATA_W-1:0] SP_INIT   = 32'h0000_0000
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    regfile_syscall_unit_if.slave bus
);
    localparam int SP_REG = 29;

    logic [DATA_W-1:0] regs [0:31];
    logic [DATA_W-1:0] r1_data;
    logic [DATA_W-1:0] r2_data;
    logic [DATA_W-1:0] led_data;
    logic              led_strobe;
    logic              halt;

    // Read ports: register 0 is hard zero, then an in-flight write to the
    // same register wins over the stored value so decode sees it this cycle.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        r1_data = '0;
        if (bus.R1Adr != 5'd0) begin
            if (bus.WE && (bus.WAdr == bus.R1Adr))
                r1_data = bus.RDin;
            else
                r1_data = regs[bus.R1Adr];
        end
    end

    always_comb begin
        r2_data = '0;
        if (bus.R2Adr != 5'd0) begin
            if (bus.WE && (bus.WAdr == bus.R2Adr))
                r2_data = bus.RDin;
            else
                r2_data = regs[bus.R2Adr];
        end
    end

    // Register array. Entry 0 is only ever loaded with zero, so the debug
    // port can index it directly and still read 0.
    // NOTE: the whole array is reset because software relies on known GPR
    // contents ($sp in particular); this rules out mapping it onto a RAM
    // macro, which is acceptable at 32 entries.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            for (int i = 0; i < 32; i++)
                regs[i] <= (i == SP_REG) ? SP_INIT : '0;
        end else if (bus.WE && (bus.WAdr != 5'd0)) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge values regardless of block order.
            regs[bus.WAdr] <= bus.RDin;
        end
    end

    // SYSCALL: $v0 arrives on R1 and $a0 on R2 (forced by operand select),
    // bypassed values included. Once halted, further syscalls are ignored
    // until reset; register writes keep going so the pipeline can drain.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            led_data   <= '0;
            led_strobe <= 1'b0;
            halt       <= 1'b0;
        end else begin
            led_strobe <= 1'b0;
            if (bus.Syscall && !halt) begin
                if (r1_data == HALT_CODE) begin
                    halt <= 1'b1;
                end else begin
                    led_data   <= r2_data;
                    led_strobe <= 1'b1;
                end
            end
        end
    end

    assign bus.R1        = r1_data;
    assign bus.R2        = r2_data;
    assign bus.DbgData   = regs[bus.DbgAdr];
    assign bus.LedData   = led_data;
    assign bus.LedStrobe = led_strobe;
    assign bus.Halt      = halt;
endmodule

// File: tb/tb_regfile_syscall_unit.sv
// -----------------------------------------------------------------------------
// tb_regfile_syscall_unit
//   Self-checking bench: directed scenarios with literal expectations, then
//   randomized traffic compared every cycle against a behavioural model.
// -----------------------------------------------------------------------------
module tb_regfile_syscall_unit;
    localparam logic [31:0] SP_INIT   = 32'h0000_3FFC;
    localparam logic [31:0] HALT_CODE = 32'd10;

    logic CLK = 1'b0;
    logic RST_N;

    regfile_syscall_unit_if #(.DATA_W(32)) bus ();

    regfile_syscall_unit #(
        .DATA_W    (32),
        .HALT_CODE (HALT_CODE),
        .SP_INIT   (SP_INIT)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_regs [32];
    logic [31:0] m_led;
    logic        m_strobe;
    logic        m_halt;
    bit          m_valid = 1'b0;

    function automatic logic [31:0] m_read(input logic [4:0] adr);
        if (adr == 0) return 32'd0;
        if (bus.WE && bus.WAdr == adr) return bus.RDin;
        return m_regs[adr];
    endfunction

    always @(posedge CLK) begin
        logic [31:0] v0, a0;
        if (!RST_N) begin
            foreach (m_regs[i]) m_regs[i] = 32'd0;
            m_regs[29] = SP_INIT;
            m_led      = 32'd0;
            m_strobe   = 1'b0;
            m_halt     = 1'b0;
            m_valid    = 1'b1;
        end else if (m_valid) begin
            v0 = m_read(bus.R1Adr);
            a0 = m_read(bus.R2Adr);
            if (bus.WE && bus.WAdr != 0) m_regs[bus.WAdr] = bus.RDin;
            m_strobe = 1'b0;
            if (bus.Syscall && !m_halt) begin
                if (v0 == HALT_CODE) m_halt = 1'b1;
                else begin
                    m_led    = a0;
                    m_strobe = 1'b1;
                end
            end
        end
    end

    // Compare every cycle once the model has seen a reset.
    always @(negedge CLK) begin
        if (m_valid) begin
            check("r1",         bus.R1,        m_read(bus.R1Adr));
            check("r2",         bus.R2,        m_read(bus.R2Adr));
            check("dbg_data",   bus.DbgData,   (bus.DbgAdr == 0) ? 32'd0 : m_regs[bus.DbgAdr]);
            check("led_data",   bus.LedData,   m_led);
            check("led_strobe", {31'd0, bus.LedStrobe}, {31'd0, m_strobe});
            check("halt",       {31'd0, bus.Halt},      {31'd0, m_halt});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic we, input logic [4:0] wadr, input logic [31:0] rdin,
                         input logic [4:0] r1a, input logic [4:0] r2a,
                         input logic sys, input logic [4:0] dbg);
        bus.WE      = we;
        bus.WAdr    = wadr;
        bus.RDin    = rdin;
        bus.R1Adr   = r1a;
        bus.R2Adr   = r2a;
        bus.Syscall = sys;
        bus.DbgAdr  = dbg;
    endtask

    initial begin
        // Reset held two cycles while a write and a syscall are requested.
        RST_N = 1'b0;
        drive(1'b1, 5'd5, 32'hFFFF_FFFF, 5'd0, 5'd0, 1'b1, 5'd0);
        cyc();
        cyc();
        RST_N = 1'b1;
        drive(1'b0, 5'd0, 32'd0, 5'd29, 5'd5, 1'b0, 5'd5);
        #1;
        check("rst_sp",     bus.R1,        32'h0000_3FFC);
        check("rst_r5",     bus.R2,        32'd0);
        check("rst_dbg5",   bus.DbgData,   32'd0);
        check("rst_halt",   {31'd0, bus.Halt},      32'd0);
        check("rst_led",    bus.LedData,   32'd0);
        check("rst_strobe", {31'd0, bus.LedStrobe}, 32'd0);

        // Write with bypass, debug port shows it only after the edge.
        cyc();
        drive(1'b1, 5'd8, 32'hDEAD_BEEF, 5'd8, 5'd0, 1'b0, 5'd8);
        #1;
        check("byp_r1",     bus.R1,      32'hDEAD_BEEF);
        check("byp_dbg_pre", bus.DbgData, 32'd0);
        cyc();
        drive(1'b0, 5'd0, 32'd0, 5'd8, 5'd0, 1'b0, 5'd8);
        #1;
        check("byp_dbg_post", bus.DbgData, 32'hDEAD_BEEF);
        check("byp_r1_post",  bus.R1,      32'hDEAD_BEEF);

        // Register 0 ignores writes.
        cyc();
        drive(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 1'b0, 5'd0);
        #1;
        check("zero_r1_pre", bus.R1, 32'd0);
        check("zero_r2_pre", bus.R2, 32'd0);
        cyc();
        drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0, 5'd0);
        #1;
        check("zero_r1_post", bus.R1,      32'd0);
        check("zero_dbg",     bus.DbgData, 32'd0);

        // Display syscall.
        cyc(); drive(1'b1, 5'd2, 32'd34, 5'd0, 5'd0, 1'b0, 5'd0);
        cyc(); drive(1'b1, 5'd4, 32'h1234_5678, 5'd0, 5'd0, 1'b0, 5'd0);
        cyc(); drive(1'b0, 5'd0, 32'd0, 5'd2, 5'd4, 1'b1, 5'd0);
        #1;
        check("disp_same_r2", bus.R2, 32'h1234_5678);
        cyc(); drive(1'b0, 5'd0, 32'd0, 5'd2, 5'd4, 1'b0, 5'd0);
        #1;
        check("disp_led",    bus.LedData, 32'h1234_5678);
        check("disp_strobe", {31'd0, bus.LedStrobe}, 32'd1);
        check("disp_halt",   {31'd0, bus.Halt},      32'd0);
        cyc();
        check("disp_strobe_drop", {31'd0, bus.LedStrobe}, 32'd0);

        // Halt via bypassed $v0.
        drive(1'b1, 5'd2, 32'd10, 5'd2, 5'd4, 1'b1, 5'd0);
        cyc(); drive(1'b0, 5'd0, 32'd0, 5'd2, 5'd4, 1'b0, 5'd0);
        #1;
        check("halt_set",    {31'd0, bus.Halt},      32'd1);
        check("halt_led",    bus.LedData, 32'h1234_5678);
        check("halt_strobe", {31'd0, bus.LedStrobe}, 32'd0);
        // Writes still land while halted; a later display syscall is ignored.
        cyc(); drive(1'b1, 5'd2, 32'd1, 5'd0, 5'd0, 1'b0, 5'd0);
        cyc(); drive(1'b1, 5'd4, 32'd7, 5'd0, 5'd0, 1'b0, 5'd0);
        cyc(); drive(1'b0, 5'd0, 32'd0, 5'd2, 5'd4, 1'b1, 5'd2);
        #1;
        check("halt_write_drain", bus.DbgData, 32'd1);
        cyc(); drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0, 5'd4);
        #1;
        check("halt_ign_led",    bus.LedData, 32'h1234_5678);
        check("halt_ign_strobe", {31'd0, bus.LedStrobe}, 32'd0);
        check("halt_sticky",     {31'd0, bus.Halt},      32'd1);
        check("halt_dbg4",       bus.DbgData, 32'd7);

        // Reset while halted, with a write in the reset cycle.
        RST_N = 1'b0;
        drive(1'b1, 5'd9, 32'h0000_0ABC, 5'd0, 5'd0, 1'b0, 5'd0);
        cyc();
        RST_N = 1'b1;
        drive(1'b0, 5'd0, 32'd0, 5'd8, 5'd29, 1'b0, 5'd9);
        #1;
        check("rst2_halt", {31'd0, bus.Halt}, 32'd0);
        check("rst2_r9",   bus.DbgData, 32'd0);
        check("rst2_r8",   bus.R1,      32'd0);
        check("rst2_sp",   bus.R2,      32'h0000_3FFC);
        check("rst2_led",  bus.LedData, 32'd0);

        // Randomized traffic, checked every cycle by the compare process.
        for (int n = 0; n < 3000; n++) begin
            logic        sys;
            logic [31:0] d;
            cyc();
            RST_N = ($urandom_range(0, 299) != 0);
            sys   = ($urandom_range(0, 5) == 0);
            case ($urandom_range(0, 3))
                0:       d = HALT_CODE;
                1:       d = $urandom_range(0, 15);
                default: d = $urandom;
            endcase
            drive($urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), d,
                  sys && ($urandom_range(0, 3) != 0) ? 5'd2 : 5'($urandom_range(0, 31)),
                  sys && ($urandom_range(0, 3) != 0) ? 5'd4 : 5'($urandom_range(0, 31)),
                  sys, 5'($urandom_range(0, 31)));
        end
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
